// File: rtl/memory_stage.sv
// memory_stage: pipeline memory-access stage. It launches at most one data-bus
// request per instruction, holds the request until the response handshake,
// extracts and extends the load data, and registers the result for writeback.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   moduleIn                 execute/memory pipeline register (REG_EX_MEM)
//   moduleOut                registered memory/writeback result (REG_MEM_WB)
//   dreq_valid/addr/size     data-bus request; fields are registered
//   dreq_strobe/data         byte-lane write enables and lane-shifted store data
//   dresp_data_ok/data       response pulse and raw 64-bit aligned read data
//   ok_to_proceed            this stage allows the pipeline to advance
//   ok_to_proceed_overall    global advance (AND of all stage ok flags)

package mem_pkg;
  typedef struct packed {
    logic        valid;
    logic        isMemRead;
    logic        isMemWrite;
    logic [2:0]  funct3;
    logic [63:0] aluOut;
    logic [63:0] storeData;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        regWrite;
  } REG_EX_MEM;

  typedef struct packed {
    logic        valid;
    logic [63:0] memOut;
    logic        isMemRead;
    logic [63:0] aluOut;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        regWrite;
  } REG_MEM_WB;
endpackage

module memory_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  REG_EX_MEM   moduleIn,
  output REG_MEM_WB   moduleOut,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        ok_to_proceed,
  input  logic        ok_to_proceed_overall
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_funct3;
  logic [63:0] r_buf;

  logic        w_is_mem;
  logic        w_launch;
  logic [5:0]  w_wsh;
  logic [7:0]  w_mask;
  logic [7:0]  w_strobe;
  logic [63:0] w_wdata;
  logic [63:0] w_rsh;
  logic [63:0] w_ldata;

  assign w_is_mem = moduleIn.valid & (moduleIn.isMemRead | moduleIn.isMemWrite);
  assign w_launch = (r_state == S_IDLE) & w_is_mem;

  // Store path: size-wide byte mask and data moved to their byte lane.
  assign w_wsh = {moduleIn.aluOut[2:0], 3'b000};

  always_comb begin
    w_mask = 8'h00;
    case (moduleIn.funct3[1:0])
      2'd0: w_mask = 8'h01;
      2'd1: w_mask = 8'h03;
      2'd2: w_mask = 8'h0F;
      2'd3: w_mask = 8'hFF;
      default: w_mask = 8'h00;
    endcase
  end

  // Loads never assert byte enables or drive store data.
  assign w_strobe = moduleIn.isMemWrite ? (w_mask << moduleIn.aluOut[2:0]) : 8'h00;
  assign w_wdata  = moduleIn.isMemWrite ? (moduleIn.storeData << w_wsh) : 64'h0;

  // Load path uses the registered request, since moduleIn may not be
  // meaningful while the response is pending.
  assign w_rsh = dresp_data >> {dreq_addr[2:0], 3'b000};

  always_comb begin
    w_ldata = w_rsh;
    case (r_funct3)
      3'b000:  w_ldata = {{56{w_rsh[7]}},  w_rsh[7:0]};
      3'b001:  w_ldata = {{48{w_rsh[15]}}, w_rsh[15:0]};
      3'b010:  w_ldata = {{32{w_rsh[31]}}, w_rsh[31:0]};
      3'b011:  w_ldata = w_rsh;
      3'b100:  w_ldata = {56'h0, w_rsh[7:0]};
      3'b101:  w_ldata = {48'h0, w_rsh[15:0]};
      3'b110:  w_ldata = {32'h0, w_rsh[31:0]};
      default: w_ldata = w_rsh;
    endcase
  end

  // Next-state and ready flag. The launch cycle itself is not ready: the
  // instruction must stay in place until its response has been captured.
  always_comb begin
    w_state_nxt   = r_state;
    ok_to_proceed = 1'b0;
    case (r_state)
      S_IDLE: begin
        ok_to_proceed = ~w_is_mem;
        if (w_is_mem) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (dresp_data_ok) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        ok_to_proceed = 1'b1;
        if (ok_to_proceed_overall) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Request registers and result buffer. A response outside WAIT is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dreq_valid  <= 1'b0;
      dreq_addr   <= 64'h0;
      dreq_size   <= 3'd0;
      dreq_strobe <= 8'h00;
      dreq_data   <= 64'h0;
      r_funct3    <= 3'd0;
      r_buf       <= 64'h0;
    end else if (w_launch) begin
      dreq_valid  <= 1'b1;
      dreq_addr   <= moduleIn.aluOut;
      dreq_size   <= {1'b0, moduleIn.funct3[1:0]};
      dreq_strobe <= w_strobe;
      dreq_data   <= w_wdata;
      r_funct3    <= moduleIn.funct3;
    end else if ((r_state == S_WAIT) && dresp_data_ok) begin
      dreq_valid  <= 1'b0;
      r_buf       <= w_ldata;
    end
  end

  // Writeback register: advance copies the instruction, otherwise a bubble
  // is inserted while the remaining fields hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      moduleOut <= '0;
    end else if (ok_to_proceed_overall) begin
      moduleOut.valid     <= moduleIn.valid;
      moduleOut.memOut    <= moduleIn.isMemRead ? r_buf : 64'h0;
      moduleOut.isMemRead <= moduleIn.isMemRead;
      moduleOut.aluOut    <= moduleIn.aluOut;
      moduleOut.pc        <= moduleIn.pc;
      moduleOut.rd        <= moduleIn.rd;
      moduleOut.regWrite  <= moduleIn.regWrite;
    end else begin
      moduleOut.valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed-vector bench for memory_stage. The global advance
// is modelled as this stage's ok flag ANDed with a bench-controlled gate that
// stands in for the other pipeline stages.

module tb_memory_stage;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  REG_EX_MEM   mi;
  REG_MEM_WB   mo;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        ok;
  logic        overall;
  logic        gate;

  int n_chk;
  int n_err;

  assign overall = ok & gate;

  memory_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .moduleIn              (mi),
    .moduleOut             (mo),
    .dreq_valid            (dreq_valid),
    .dreq_addr             (dreq_addr),
    .dreq_size             (dreq_size),
    .dreq_strobe           (dreq_strobe),
    .dreq_data             (dreq_data),
    .dresp_data_ok         (dresp_data_ok),
    .dresp_data            (dresp_data),
    .ok_to_proceed         (ok),
    .ok_to_proceed_overall (overall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic r, input logic w, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] sd);
    mi           = '0;
    mi.valid     = v;
    mi.isMemRead = r;
    mi.isMemWrite= w;
    mi.funct3    = f3;
    mi.aluOut    = addr;
    mi.storeData = sd;
    mi.pc        = 64'h8000_0000 + addr;
    mi.rd        = 5'd7;
    mi.regWrite  = r;
  endtask

  // One-cycle response pulse starting now; returns just after the edge.
  task automatic resp(input logic [63:0] d);
    dresp_data_ok = 1'b1;
    dresp_data    = d;
    tick();
    dresp_data_ok = 1'b0;
    dresp_data    = 64'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    gate = 1'b1;
    dresp_data_ok = 1'b0;
    dresp_data = 64'h0;
    mi = '0;

    // Reset state
    #3;
    chk("rst_dreq_valid", {63'h0, dreq_valid}, 64'h0);
    chk("rst_strobe", {56'h0, dreq_strobe}, 64'h0);
    chk("rst_addr", dreq_addr, 64'h0);
    chk("rst_out_valid", {63'h0, mo.valid}, 64'h0);
    chk("rst_memout", mo.memOut, 64'h0);
    chk("rst_ok", {63'h0, ok}, 64'h1);
    tick();
    rst = 1'b1;

    // ALU op: ready immediately, one-cycle pass-through
    set_in(1'b1, 1'b0, 1'b0, 3'b000, 64'h1234, 64'h0);
    #2 chk("alu_ok", {63'h0, ok}, 64'h1);
    tick();
    chk("alu_out_valid", {63'h0, mo.valid}, 64'h1);
    chk("alu_memout", mo.memOut, 64'h0);
    chk("alu_aluout", mo.aluOut, 64'h1234);
    chk("alu_rd", {59'h0, mo.rd}, 64'h7);
    chk("alu_no_req", {63'h0, dreq_valid}, 64'h0);
    set_in(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);

    // LB 0x1003, response after 3 WAIT cycles
    set_in(1'b1, 1'b1, 1'b0, 3'b000, 64'h1003, 64'h0);
    #2 chk("lb_launch_ok", {63'h0, ok}, 64'h0);
    tick();
    chk("lb_dreq_valid", {63'h0, dreq_valid}, 64'h1);
    chk("lb_addr", dreq_addr, 64'h1003);
    chk("lb_size", {61'h0, dreq_size}, 64'h0);
    chk("lb_strobe", {56'h0, dreq_strobe}, 64'h0);
    chk("lb_wait_ok", {63'h0, ok}, 64'h0);
    chk("lb_bubble", {63'h0, mo.valid}, 64'h0);
    tick();
    tick();
    chk("lb_held_valid", {63'h0, dreq_valid}, 64'h1);
    chk("lb_held_addr", dreq_addr, 64'h1003);
    resp(64'h0000_0000_8000_0000);
    chk("lb_done_dreq", {63'h0, dreq_valid}, 64'h0);
    chk("lb_done_ok", {63'h0, ok}, 64'h1);
    tick();
    chk("lb_out_valid", {63'h0, mo.valid}, 64'h1);
    chk("lb_memout", mo.memOut, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_isread", {63'h0, mo.isMemRead}, 64'h1);
    set_in(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    #2 chk("lb_idle_ok", {63'h0, ok}, 64'h1);

    // LHU 0x2006, earliest response (N=1)
    set_in(1'b1, 1'b1, 1'b0, 3'b101, 64'h2006, 64'h0);
    tick();
    chk("lhu_size", {61'h0, dreq_size}, 64'h1);
    resp(64'hBEEF_0000_0000_0000);
    tick();
    chk("lhu_memout", mo.memOut, 64'h0000_0000_0000_BEEF);
    set_in(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);

    // SW 0x3004
    set_in(1'b1, 1'b0, 1'b1, 3'b010, 64'h3004, 64'h1122_3344);
    tick();
    chk("sw_size", {61'h0, dreq_size}, 64'h2);
    chk("sw_strobe", {56'h0, dreq_strobe}, 64'hF0);
    chk("sw_data", dreq_data, 64'h1122_3344_0000_0000);
    tick();
    chk("sw_held_valid", {63'h0, dreq_valid}, 64'h1);
    chk("sw_held_strobe", {56'h0, dreq_strobe}, 64'hF0);
    chk("sw_held_data", dreq_data, 64'h1122_3344_0000_0000);
    resp(64'hDEAD_BEEF_DEAD_BEEF);
    chk("sw_done_dreq", {63'h0, dreq_valid}, 64'h0);
    tick();
    chk("sw_out_valid", {63'h0, mo.valid}, 64'h1);
    chk("sw_memout", mo.memOut, 64'h0);
    set_in(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);

    // SB at top byte lane
    set_in(1'b1, 1'b0, 1'b1, 3'b000, 64'h6007, 64'hAB);
    tick();
    chk("sb_strobe", {56'h0, dreq_strobe}, 64'h80);
    chk("sb_data", dreq_data, 64'hAB00_0000_0000_0000);
    resp(64'h0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);

    // LWU zero extension
    set_in(1'b1, 1'b1, 1'b0, 3'b110, 64'h5004, 64'h0);
    tick();
    resp(64'hF000_0000_0000_0000);
    tick();
    chk("lwu_memout", mo.memOut, 64'h0000_0000_F000_0000);
    set_in(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);

    // LD held in DONE by a stalled pipeline for 4 cycles
    set_in(1'b1, 1'b1, 1'b0, 3'b011, 64'h4000, 64'h0);
    tick();
    gate = 1'b0;
    resp(64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ld_stall_valid", {63'h0, mo.valid}, 64'h0);
      chk("ld_stall_dreq", {63'h0, dreq_valid}, 64'h0);
      chk("ld_stall_ok", {63'h0, ok}, 64'h1);
    end
    gate = 1'b1;
    tick();
    chk("ld_out_valid", {63'h0, mo.valid}, 64'h1);
    chk("ld_memout", mo.memOut, 64'h0123_4567_89AB_CDEF);
    set_in(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    tick();
    chk("ld_valid_once", {63'h0, mo.valid}, 64'h0);
    chk("ld_no_second_req", {63'h0, dreq_valid}, 64'h0);

    // Reset during WAIT, then a late response
    set_in(1'b1, 1'b1, 1'b0, 3'b000, 64'h1003, 64'h0);
    tick();
    chk("rw_dreq_before", {63'h0, dreq_valid}, 64'h1);
    rst = 1'b0;
    #1;
    chk("rw_dreq_async", {63'h0, dreq_valid}, 64'h0);
    chk("rw_out_valid", {63'h0, mo.valid}, 64'h0);
    set_in(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    tick();
    rst = 1'b1;
    resp(64'hFFFF_FFFF_FFFF_FFFF);
    chk("rw_late_dreq", {63'h0, dreq_valid}, 64'h0);
    chk("rw_late_ok", {63'h0, ok}, 64'h1);
    tick();
    chk("rw_late_out_valid", {63'h0, mo.valid}, 64'h0);
    chk("rw_late_memout", mo.memOut, 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameters: none; widths fixed by the common package (u64 data/address, 3-bit size/funct3).
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 moduleIn  input  REG_EX_MEM  execute-stage register: valid, isMemRead, isMemWrite, funct3, aluOut (address), storeData, plus pass-through fields.
REQ-005 moduleOut  output  REG_MEM_WB  registered result for writeback: valid, memOut, isMemRead, plus pass-through fields.
REQ-006 dreq_valid  output  1  data-bus request valid.
REQ-007 dreq_addr  output  64  request address, equal to moduleIn.aluOut.
REQ-008 dreq_size  output  3  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 dreq_strobe  output  8  byte-write enables; 0 for loads.
REQ-010 dreq_data  output  64  store data shifted to its byte lane.
REQ-011 dresp_data_ok  input  1  response handshake; one-cycle pulse.
REQ-012 dresp_data  input  64  raw 64-bit aligned read data, valid with dresp_data_ok.
REQ-013 ok_to_proceed  output  1  this stage is ready for the pipeline to advance.
REQ-014 ok_to_proceed_overall  input  1  global advance (AND of all stage ok flags).

Function
REQ-015 FSM states: IDLE, WAIT, DONE.
REQ-016 IDLE, moduleIn.valid and (isMemRead or isMemWrite): go to WAIT next edge; dreq_valid registered to 1; addr, size, strobe, data registered.
REQ-017 WAIT: all dreq_* outputs held stable until dresp_data_ok=1.
REQ-018 WAIT with dresp_data_ok=1: dreq_valid<=0; extracted load data captured into result buffer; go to DONE.
REQ-019 dresp_data_ok in IDLE or DONE: ignored; no state or buffer change.
REQ-020 dreq_size = funct3[1:0]; byte offset o = aluOut[2:0].
REQ-021 Strobe: size-wide mask of ones shifted left by o.
REQ-022 Store data: storeData shifted left by 8*o.
REQ-023 Load extraction: dresp_data >> 8*o, then extended per funct3: 000 LB sign, 001 LH sign, 010 LW sign, 011 LD, 100 LBU zero, 101 LHU zero, 110 LWU zero.
REQ-024 Alignment is guaranteed upstream; this stage performs no misalignment check.
REQ-025 ok_to_proceed = 1 in DONE, or in IDLE when moduleIn is invalid or not a memory op; 0 in WAIT and in the IDLE cycle that launches a request.
REQ-026 On posedge with ok_to_proceed_overall=1: moduleOut.valid<=moduleIn.valid; pass-through fields copied; memOut<=buffer for loads, else 0; DONE goes to IDLE.
REQ-027 On posedge with ok_to_proceed_overall=0: moduleOut.valid<=0 (bubble); other moduleOut fields hold.
REQ-028 Latency: non-memory op takes 1 cycle; memory op takes 2 + N cycles, where N is the number of cycles from dreq_valid rising to the dresp_data_ok pulse (N >= 1).
REQ-029 The earliest response is the cycle after dreq_valid first reads 1; a same-cycle response is impossible by construction.
REQ-030 One outstanding request at most; no new request until the FSM is back in IDLE.

Reset
REQ-031 rst=0 asynchronously forces: state IDLE, dreq_valid 0, dreq_strobe 0, dreq_addr/size/data 0, buffer 0, moduleOut all fields 0.
REQ-032 Reset during WAIT abandons the request; a late dresp_data_ok after release is ignored (REQ-019).
REQ-033 First request is launched no earlier than the first posedge after rst returns to 1.

Verification
REQ-034 ALU op (valid, no mem), ok_to_proceed_overall=1 -> ok_to_proceed=1 same cycle; next edge moduleOut.valid=1, memOut=0.
REQ-035 LB, addr 0x1003, dresp_data=0x0000_0000_8000_0000 after 3 cycles -> dreq_size=0, strobe=0x00; DONE; memOut=0xFFFF_FFFF_FFFF_FF80.
REQ-036 LHU, addr 0x2006, dresp_data=0xBEEF_0000_0000_0000 -> memOut=0x0000_0000_0000_BEEF.
REQ-037 SW, addr 0x3004, storeData=0x1122_3344 -> dreq_strobe=0xF0, dreq_data=0x1122_3344_0000_0000, held until dresp_data_ok; then moduleOut.valid=1.
REQ-038 Load in DONE with ok_to_proceed_overall=0 for 4 cycles -> stays DONE, moduleOut.valid=0 each cycle, no second request; advance -> valid=1 once.
REQ-039 rst=0 mid-WAIT, then spurious dresp_data_ok after release -> dreq_valid=0 immediately, state IDLE, moduleOut.valid stays 0.
